// File: rtl/store_rmw_unit.sv
// Read-modify-write store sequencer: word stores write directly, byte/halfword stores fetch, merge and write back.
// Define STORE_ALIGN_CHECK_EN to abort misaligned word/halfword stores with err and no memory access.
module store_rmw_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_e;
    typedef enum logic [1:0] {OP_WORD = 2'b00, OP_HALF = 2'b01, OP_BYTE = 2'b10, OP_NONE = 2'b11} op_e;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       data_q, data_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              misalign;
    logic              wd_expire;
    logic [31:0]       merged;

    always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
        misalign = ((op_e'(op) == OP_WORD) && (addr[1:0] != 2'b00)) ||
                   ((op_e'(op) == OP_HALF) && addr[0]);
`else
        misalign = 1'b0;
`endif
        wd_expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

        merged = mdr_q;
        if (op_q == OP_BYTE) begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end

        state_d    = state_q;
        op_d       = op_q;
        lane_d     = lane_q;
        data_d     = data_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        mdr_d      = mdr_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op_e'(op);
                    lane_d     = addr[1:0];
                    data_d     = store_data[15:0];
                    mem_addr_d = {addr[31:2], 2'b00};
                    cnt_d      = '0;
                    if (misalign) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        case (op_e'(op))
                            OP_WORD: begin
                                state_d = WRITE;
                                wdata_d = store_data;
                            end
                            OP_HALF, OP_BYTE: state_d = READ;
                            default:          state_d = DONE;
                        endcase
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = MERGE;
                end else if (wd_expire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MERGE: begin
                wdata_d = merged;
                cnt_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = DONE;
                end else if (wd_expire) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with the state they describe.
        mem_re_d = (state_d == READ);
        mem_we_d = (state_d == WRITE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= OP_WORD;
            lane_q     <= '0;
            data_q     <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            mdr_q      <= '0;
            cnt_q      <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            data_q     <= data_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            mdr_q      <= mdr_d;
            cnt_q      <= cnt_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = wdata_q;
    assign mdr       = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with a small memory responder of programmable ack latency.
// Expected values follow STORE_ALIGN_CHECK_EN when the bench is built with that macro.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mdr;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    store_rmw_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .store_data (store_data),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mdr        (mdr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responder: acks after ack_delay waiting cycles of an active request.
    logic [31:0] mem_word;
    int          ack_delay;
    bit          ack_never;
    bit          ack_never_wr;
    int          wcnt;

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        if (reset_n && (mem_re || mem_we) && !ack_never && !(mem_we && ack_never_wr)) begin
            if (wcnt == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_re) mem_rdata = mem_word;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    logic [31:0] wr_data;
    int          wr_cnt;
    int          overlap_cnt = 0;

    always @(posedge clk) begin
        if (mem_we && mem_ack) begin
            wr_data = mem_wdata;
            wr_cnt++;
        end
        if (mem_re && mem_we) overlap_cnt++;
    end

    int          done_cyc;
    logic        err_at_done;
    int          re_cnt;
    int          we_cnt;
    int          first_we_cyc;
    int          last_re_cyc;
    logic [31:0] first_wdata;
    logic [31:0] addr_seen;

    task automatic run_store(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        int cyc;
        done_cyc     = 0;
        err_at_done  = 1'b0;
        re_cnt       = 0;
        we_cnt       = 0;
        first_we_cyc = 0;
        last_re_cyc  = 0;
        first_wdata  = '0;
        addr_seen    = '0;
        wr_cnt       = 0;
        wr_data      = '0;
        @(negedge clk);
        start      = 1'b1;
        op         = o;
        addr       = a;
        store_data = d;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 60) begin
            if (cyc == 1) addr_seen = mem_addr;
            if (mem_re) begin
                re_cnt++;
                last_re_cyc = cyc;
            end
            if (mem_we) begin
                we_cnt++;
                if (first_we_cyc == 0) begin
                    first_we_cyc = cyc;
                    first_wdata  = mem_wdata;
                end
            end
            if (done) begin
                done_cyc    = cyc;
                err_at_done = err;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        op           = 2'b00;
        addr         = '0;
        store_data   = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        mem_word     = 32'h11223344;
        ack_delay    = 0;
        ack_never    = 1'b0;
        ack_never_wr = 1'b0;
        wcnt         = 0;
        wr_cnt       = 0;
        wr_data      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_re_we", {30'd0, mem_re, mem_we}, 32'd0);
        check("rst_done",  {30'd0, done, err}, 32'd0);
        check("rst_mdr",   mdr, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        reset_n = 1'b1;

        // Word store, immediate ack
        run_store(2'b00, 32'h100, 32'hDEADBEEF);
        check("w_we_cyc",  32'(first_we_cyc), 32'd1);
        check("w_wdata",   first_wdata, 32'hDEADBEEF);
        check("w_done",    32'(done_cyc), 32'd2);
        check("w_no_re",   32'(re_cnt), 32'd0);
        check("w_err",     32'(err_at_done), 32'd0);
        check("w_addr",    addr_seen, 32'h100);
        check("w_written", wr_data, 32'hDEADBEEF);

        // Byte store into lane 2
        run_store(2'b10, 32'h102, 32'h000000AA);
        check("b_mdr",     mdr, 32'h11223344);
        check("b_written", wr_data, 32'h11AA3344);
        check("b_done",    32'(done_cyc), 32'd4);
        check("b_err",     32'(err_at_done), 32'd0);

        // Halfword upper, every ack delayed 3 cycles
        ack_delay = 3;
        run_store(2'b01, 32'h202, 32'h0000BEEF);
        check("h_written", wr_data, 32'hBEEF3344);
        check("h_done",    32'(done_cyc), 32'd10);
        check("h_addr",    addr_seen, 32'h200);
        ack_delay = 0;

        // Watchdog expiry during READ
        mem_word  = 32'hCAFEF00D;
        ack_never = 1'b1;
        run_store(2'b10, 32'h300, 32'h00000055);
        check("t_re_cnt",  32'(re_cnt), 32'd4);
        check("t_re_last", 32'(last_re_cyc), 32'd4);
        check("t_done",    32'(done_cyc), 32'd5);
        check("t_err",     32'(err_at_done), 32'd1);
        check("t_no_we",   32'(we_cnt), 32'd0);
        check("t_no_wr",   32'(wr_cnt), 32'd0);
        check("t_mdr_hold", mdr, 32'h11223344);
        ack_never = 1'b0;
        mem_word  = 32'h11223344;

        // Reserved op completes without access
        run_store(2'b11, 32'h400, 32'hFFFFFFFF);
        check("n_done",  32'(done_cyc), 32'd1);
        check("n_err",   32'(err_at_done), 32'd0);
        check("n_acc",   32'(re_cnt + we_cnt), 32'd0);

        // Halfword at an odd address
        run_store(2'b01, 32'h101, 32'h00005566);
`ifdef STORE_ALIGN_CHECK_EN
        check("ma_done", 32'(done_cyc), 32'd1);
        check("ma_err",  32'(err_at_done), 32'd1);
        check("ma_acc",  32'(re_cnt + we_cnt), 32'd0);
`else
        check("ma_written", wr_data, 32'h11225566);
        check("ma_done",    32'(done_cyc), 32'd4);
        check("ma_err",     32'(err_at_done), 32'd0);
`endif

        // Remaining lanes and halfword lower
        run_store(2'b10, 32'h203, 32'h00000077);
        check("b3_written", wr_data, 32'h77223344);
        run_store(2'b10, 32'h200, 32'hFFFFFF99);
        check("b0_written", wr_data, 32'h11223399);
        run_store(2'b01, 32'h300, 32'hFFFFCAFE);
        check("h0_written", wr_data, 32'h1122CAFE);

        // Word store with ack held low two cycles
        ack_delay = 2;
        run_store(2'b00, 32'h104, 32'h01234567);
        check("wd_done",    32'(done_cyc), 32'd4);
        check("wd_written", wr_data, 32'h01234567);
        ack_delay = 0;

        // Reset asserted while a sub-word store sits in WRITE
        ack_never_wr = 1'b1;
        @(negedge clk);
        start      = 1'b1;
        op         = 2'b10;
        addr       = 32'h101;
        store_data = 32'h00000055;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("r_pre_we",  32'(mem_we), 32'd1);
        check("r_pre_mdr", mdr, 32'h11223344);
        reset_n = 1'b0;
        #1;
        check("r_we",   32'(mem_we), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_mdr",  mdr, 32'd0);
        @(negedge clk);
        reset_n      = 1'b1;
        ack_never_wr = 1'b0;
        run_store(2'b10, 32'h101, 32'h00000055);
        check("r_written", wr_data, 32'h11225544);
        check("r_done",    32'(done_cyc), 32'd4);

        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
